block_buffer_ctrl: RTL and testbench
====================================

// Module: block_buffer_ctrl
// PURPOSE
//  Single-clock sequencer for the acquisition block buffer (dual-port RAM, 1-cycle registered read).
//  Write side: assigns ring addresses to incoming raw-sample words.
//  Read side: when a full block of 2^BBITS words is present, requests the DRAM writer and streams
//  that block out. Tracks fill level and flags sample overflow.
//  Sits between the acquisition front-end and the DRAM write path.
// PARAMETERS
//  ABITS  9   buffer address width; DEPTH = 2^ABITS words
//  BBITS  4   log2 words per DRAM block; BBITS < ABITS
//  DELAY  3   simulation-only #delay on registered outputs
// PORTS
//  clk_i         in   1        single clock; buffer read and write ports both run on it
//  rst_i         in   1        synchronous, active-high reset
//  en_i          in   1        acquisition enable
//  strobe_i      in   1        raw sample word valid this cycle
//  wr_en_o       out  1        buffer write enable
//  wr_addr_o     out  ABITS    buffer write address
//  rd_addr_o     out  ABITS    buffer read address
//  dram_req_o    out  1        request: one block ready for DRAM
//  dram_ack_i    in   1        DRAM writer grants the request
//  dram_vld_o    out  1        buffer read_data valid this cycle; aligned to RAM latency
//  dram_last_o   out  1        with dram_vld_o: final word of block
//  level_o       out  ABITS-BBITS+1  complete blocks pending drain
//  overflow_o    out  1        sticky: a sample was dropped
// BEHAVIOUR
//  Reset:
//   - All outputs 0; wr_ptr = rd_ptr = 0 (ABITS+1 bits each); state IDLE.
//   - Reset mid-drain abandons the block; dram_req_o drops on the next edge.
//  Write side (combinational):
//   - fill = wr_ptr - rd_ptr, modulo 2^(ABITS+1); full = (fill == DEPTH).
//   - wr_en_o = en_i & strobe_i & ~full; wr_addr_o = wr_ptr[ABITS-1:0].
//   - wr_ptr increments on each wr_en_o cycle and wraps naturally.
//   - strobe_i & en_i & full: word dropped; overflow_o set next cycle; cleared only by rst_i.
//  Level:
//   - level_o = fill >> BBITS (complete blocks only), registered.
//   - A partial block is never drained; it stays in place if en_i falls.
//  FSM: IDLE -> REQ -> READ -> IDLE
//   - IDLE: if level_o != 0, go to REQ.
//   - REQ: dram_req_o = 1 and held until dram_ack_i; on ack go to READ with word counter = 0.
//     Ack in the same cycle req rises is legal.
//   - READ:
//     - rd_addr_o = {rd_ptr[ABITS-1:BBITS], cnt}; counter increments every cycle, no stalls.
//     - At cnt = 2^BBITS-1: rd_ptr += 2^BBITS, go to IDLE.
//   - dram_vld_o/dram_last_o are READ / (READ & cnt==max) delayed 1 cycle.
//     Data word k is valid exactly 1 cycle after its address.
//  Timing:
//   - Min latency from block-completing write to dram_req_o: 2 cycles.
//   - Back-to-back blocks: 1 IDLE cycle between drains.
//  Simultaneous events:
//   - Write and rd_ptr advance in the same cycle: both apply; fill changes by +1-2^BBITS.
//   - Space freed by rd_ptr advance is usable from the next cycle.
//   - Write to a location being read: impossible, since reads cover only complete blocks
//     and full blocks writes.
//  Widths: all pointer arithmetic unsigned, ABITS+1 bits, modulo wrap.
// STRUCTURE
//  Shared package/header (tartcfg.v): FSM state encodings (IDLE/REQ/READ), BBITS default.
//  No sub-module. Instantiated beside block_buffer with read_clock_i = write_clock_i = clk_i.
// TESTING
//  1. Reset, en_i=1, 16 strobes of words 0..15 -> dram_req_o high 2 cycles after the 16th.
//     Ack -> rd_addr_o 0..15; dram_vld_o for 16 cycles; dram_last_o on word 15; data 0..15.
//  2. dram_ack_i held low 50 cycles with continuous strobes -> dram_req_o stays high.
//     level_o reaches 3 at 48 words. After ack, blocks drain back-to-back, one IDLE gap each.
//  3. No ack, 520 strobes -> wr_en_o low after word 512; overflow_o=1 on cycle 513, sticky.
//     Data at addresses 0..511 unchanged.
//  4. Run >2 ring wraps (1100 words, ack always 1) -> wr_addr_o wraps 511->0.
//     Read data sequence is continuous; overflow_o stays 0.
//  5. 10 strobes then en_i=0 -> no dram_req_o; 6 more strobes with en_i=1 -> block 0 drains.
//  6. rst_i asserted at READ cnt=7 -> next cycle all outputs 0; a fresh 16-word fill
//     drains from address 0.

Source files
------------

// File: rtl/block_buffer_ctrl_pkg.sv
// Shared definitions for the acquisition block-buffer sequencer.
package block_buffer_ctrl_pkg;

    localparam int ABITS_DEF = 9;
    localparam int BBITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_READ = 2'd2
    } state_e;

endpackage

// File: rtl/block_buffer_ctrl.sv
// Ring-address sequencer for the acquisition block buffer: writes raw samples,
// hands complete 2^BBITS-word blocks to the DRAM writer, tracks fill and overflow.
module block_buffer_ctrl
    import block_buffer_ctrl_pkg::*;
#(
    parameter int ABITS = ABITS_DEF,
    parameter int BBITS = BBITS_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   strobe_i,
    output logic                   wr_en_o,
    output logic [ABITS-1:0]       wr_addr_o,
    output logic [ABITS-1:0]       rd_addr_o,
    output logic                   dram_req_o,
    input  logic                   dram_ack_i,
    output logic                   dram_vld_o,
    output logic                   dram_last_o,
    output logic [ABITS-BBITS:0]   level_o,
    output logic                   overflow_o
);

    localparam int PW    = ABITS + 1;
    localparam int LW    = ABITS - BBITS + 1;
    localparam int DEPTH = 1 << ABITS;

    state_e               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        fill, fill_d;
    logic [BBITS-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 vld_q, last_q, ovf_q;
    logic                 full, accept, drop, cnt_max;

    assign fill    = wr_ptr_q - rd_ptr_q;
    assign full    = (fill == PW'(DEPTH));
    assign accept  = en_i & strobe_i & ~full;
    assign drop    = en_i & strobe_i & full;
    assign cnt_max = &cnt_q;

    assign wr_ptr_d = wr_ptr_q + PW'(accept);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dram_ack_i) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_max) begin
                    rd_ptr_d = rd_ptr_q + (PW'(1) << BBITS);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Level tracks the post-edge pointers so a drained block never looks pending in IDLE.
    assign fill_d  = wr_ptr_d - rd_ptr_d;
    assign level_d = LW'(fill_d >> BBITS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            vld_q    <= (state_q == ST_READ);
            last_q   <= (state_q == ST_READ) & cnt_max;
            ovf_q    <= ovf_q | drop;
        end
    end

    assign wr_en_o     = accept;
    assign wr_addr_o   = wr_ptr_q[ABITS-1:0];
    assign rd_addr_o   = {rd_ptr_q[ABITS-1:BBITS], cnt_q};
    assign dram_req_o  = (state_q == ST_REQ);
    assign dram_vld_o  = vld_q;
    assign dram_last_o = last_q;
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_block_buffer_ctrl.sv
// Scoreboard bench for block_buffer_ctrl with a behavioural dual-port RAM beside it.
module tb_block_buffer_ctrl;

    localparam int ABITS = 9;
    localparam int BBITS = 4;
    localparam int DEPTH = 512;
    localparam int BLK   = 16;

    logic                 clk = 1'b0;
    logic                 rst_i, en_i, strobe_i, dram_ack_i;
    logic                 wr_en_o, dram_req_o, dram_vld_o, dram_last_o, overflow_o;
    logic [ABITS-1:0]     wr_addr_o, rd_addr_o;
    logic [ABITS-BBITS:0] level_o;

    logic [15:0] wr_data, rd_data;
    logic [15:0] mem [DEPTH];

    logic [15:0] sb_q [$];
    int          acc, drn, pops;
    logic        ovf_exp;
    logic [15:0] word;
    int          checks = 0;
    int          failures = 0;

    block_buffer_ctrl #(.ABITS(ABITS), .BBITS(BBITS)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .strobe_i    (strobe_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .rd_addr_o   (rd_addr_o),
        .dram_req_o  (dram_req_o),
        .dram_ack_i  (dram_ack_i),
        .dram_vld_o  (dram_vld_o),
        .dram_last_o (dram_last_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (wr_en_o) mem[wr_addr_o] <= wr_data;
        rd_data <= mem[rd_addr_o];
    end

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then compare against the model.
    task automatic step(input logic en, input logic strobe, input logic ack, input logic rst = 1'b0);
        int          fill;
        logic        acc_ok;
        logic [15:0] exp_d;
        @(posedge clk);
        #1;
        rst_i      = rst;
        en_i       = en;
        strobe_i   = strobe;
        dram_ack_i = ack;
        wr_data    = word;
        #1;
        if (rst) begin
            sb_q.delete();
            acc     = 0;
            drn     = 0;
            pops    = 0;
            ovf_exp = 1'b0;
        end else begin
            if (dram_vld_o) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    exp_d = sb_q.pop_front();
                    check_val("rd_data", int'(rd_data), int'(exp_d));
                end
                check_val("dram_last", int'(dram_last_o), int'((pops % BLK) == BLK - 1));
                if ((pops % BLK) == BLK - 1) drn += BLK;
                pops++;
            end else begin
                check_val("last_without_vld", int'(dram_last_o), 0);
            end
            fill   = acc - drn;
            acc_ok = en & strobe & (fill != DEPTH);
            check_val("wr_en", int'(wr_en_o), int'(acc_ok));
            if (acc_ok) check_val("wr_addr", int'(wr_addr_o), acc % DEPTH);
            check_val("level", int'(level_o), fill / BLK);
            check_val("overflow", int'(overflow_o), int'(ovf_exp));
            if (acc_ok) begin
                sb_q.push_back(word);
                acc++;
            end else if (en & strobe) begin
                ovf_exp = 1'b1;
            end
        end
        if (strobe) word++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_req(input int limit);
        int n;
        n = 0;
        while (!dram_req_o && n < limit) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!dram_req_o) check_val("req_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gap, wraps, bad;
        logic [15:0] base;
        rst_i = 1'b1; en_i = 1'b0; strobe_i = 1'b0; dram_ack_i = 1'b0;
        wr_data = '0; word = '0;
        acc = 0; drn = 0; pops = 0; ovf_exp = 1'b0;

        // Test 1: single block, reset state, request latency and read addresses
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        check_val("rst_req", int'(dram_req_o), 0);
        check_val("rst_rd_addr", int'(rd_addr_o), 0);
        check_val("rst_wr_addr", int'(wr_addr_o), 0);
        check_val("rst_vld", int'(dram_vld_o), 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("t1_req_early", int'(dram_req_o), 0);
        step(1'b1, 1'b0, 1'b0);
        check_val("t1_req_rise", int'(dram_req_o), 1);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check_val("t1_rd_addr", int'(rd_addr_o), k);
        end
        step(1'b1, 1'b0, 1'b0);
        check_val("t1_sb_drained", sb_q.size(), 0);

        // Test 2: request held without ack, then back-to-back drains
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i >= 17) check_val("t2_req_hold", int'(dram_req_o), 1);
            if (i == 48) check_val("t2_level3", int'(level_o), 3);
        end
        gap = -1;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (dram_vld_o) begin
                if (gap >= 0) begin
                    check_val("t2_gap", gap, 2);
                    gap = -1;
                end
                if (dram_last_o) gap = 0;
            end else if (gap >= 0) begin
                gap++;
            end
        end
        check_val("t2_partial_left", sb_q.size(), 2);

        // Test 3: fill to capacity with no ack, overflow is sticky, stored data intact
        do_reset();
        base = word;
        for (int i = 0; i < 520; i++) step(1'b1, 1'b1, 1'b0);
        check_val("t3_overflow", int'(overflow_o), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t3_overflow_sticky", int'(overflow_o), 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'(base + 16'(i))) bad++;
        check_val("t3_mem_bad_words", bad, 0);

        // Test 4: more than two ring wraps with ack always granted
        do_reset();
        wraps = 0;
        for (int i = 0; i < 1100; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (wr_en_o && wr_addr_o == '0) wraps++;
        end
        check_val("t4_wraps", wraps, 3);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b1);
        check_val("t4_overflow", int'(overflow_o), 0);
        check_val("t4_partial_left", sb_q.size(), 1100 % BLK);

        // Test 5: partial block parked while disabled, completed later
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_val("t5_no_req", int'(dram_req_o), 0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        wait_req(10);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t5_sb_drained", sb_q.size(), 0);

        // Test 6: reset in the middle of a drain, then a fresh block from address 0
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
        wait_req(10);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t6_rd_addr_pre", int'(rd_addr_o), 6);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_val("t6_req", int'(dram_req_o), 0);
        check_val("t6_vld", int'(dram_vld_o), 0);
        check_val("t6_rd_addr", int'(rd_addr_o), 0);
        check_val("t6_wr_addr", int'(wr_addr_o), 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
        wait_req(10);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_val("t6_first_rd_addr", int'(rd_addr_o), 0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0);
        check_val("t6_sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
